sd_card_block_writer: RTL and testbench

Writes one 512-byte block from a byte-addressed source buffer to SD card block `block_id`, driving the existing `sd_controller` SPI engine through its write port (`wr`, `din`, `ready_for_next_byte`). It is the write-side counterpart of the block reader and is used to persist board state (e.g. a saved Game-of-Life pattern) to the card. The block fetches bytes on demand from a synchronous RAM and reports busy, done and error status to the control logic.

---
 rtl/sd_card_block_writer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sd_card_block_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_block_writer.sv
// Writes one 512-byte block from a registered-read buffer to an SD card through sd_controller.
// Optional command/busy timeout is built when SDW_TIMEOUT_EN is defined.
module sd_controller (
    input  logic        clk,
    input  logic        reset,
    output logic        cs,
    output logic        mosi,
    output logic        sclk,
    input  logic        miso,
    input  logic        rd,
    output logic [7:0]  dout,
    output logic        byte_available,
    input  logic        wr,
    input  logic [7:0]  din,
    output logic        ready,
    output logic        ready_for_next_byte,
    input  logic [31:0] address
);
    typedef enum logic [1:0] {C_INIT, C_IDLE, C_XFER, C_BUSY} cstate_t;

    localparam logic [9:0] INIT_BYTES = 10'd10;
    localparam logic [9:0] SEQ_DATA0  = 10'd15;
    localparam logic [9:0] SEQ_LAST   = 10'd529;

    cstate_t     cst;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic [2:0]  bitn;
    logic        phase;
    logic [9:0]  seq;
    logic [9:0]  seq_n;
    logic [1:0]  rfnb_cnt;
    logic        miso_q;

    // Byte stream of a write: CMD24 frame, response gap, start token, data, CRC, data response
    function automatic logic [7:0] frame_byte(input logic [9:0] s, input logic [31:0] a);
        case (s)
            10'd0:   frame_byte = 8'h58;
            10'd1:   frame_byte = a[31:24];
            10'd2:   frame_byte = a[23:16];
            10'd3:   frame_byte = a[15:8];
            10'd4:   frame_byte = a[7:0];
            10'd14:  frame_byte = 8'hFE;
            default: frame_byte = 8'hFF;
        endcase
    endfunction

    assign seq_n               = seq + 10'd1;
    assign sclk                = phase;
    assign mosi                = tx[7];
    assign dout                = rx;
    assign ready               = (cst == C_IDLE) && miso_q;
    assign ready_for_next_byte = (rfnb_cnt != 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cst            <= C_INIT;
            cs             <= 1'b1;
            tx             <= 8'hFF;
            rx             <= 8'h00;
            bitn           <= 3'd0;
            phase          <= 1'b0;
            seq            <= 10'd0;
            rfnb_cnt       <= 2'd0;
            miso_q         <= 1'b0;
            byte_available <= 1'b0;
        end else begin
            miso_q         <= miso;
            byte_available <= 1'b0;
            if (rfnb_cnt != 2'd0) rfnb_cnt <= rfnb_cnt - 2'd1;
            case (cst)
                C_IDLE: if (wr) begin
                    cs    <= 1'b0;
                    seq   <= 10'd0;
                    tx    <= frame_byte(10'd0, address);
                    bitn  <= 3'd0;
                    phase <= 1'b0;
                    cst   <= C_XFER;
                end
                C_INIT, C_XFER: begin
                    phase <= ~phase;
                    if (phase) begin
                        rx   <= {rx[6:0], miso};
                        tx   <= {tx[6:0], 1'b1};
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
                            byte_available <= rd;
                            if (cst == C_INIT) begin
                                seq <= seq_n;
                                if (seq == INIT_BYTES - 10'd1) cst <= C_IDLE;
                            end else if (seq == SEQ_LAST) begin
                                cst <= C_BUSY;
                            end else begin
                                seq <= seq_n;
                                // Data bytes are taken from din; the stretched strobe tells the writer
                                if (seq_n >= SEQ_DATA0 && seq_n < SEQ_DATA0 + 10'd512) begin
                                    tx       <= din;
                                    rfnb_cnt <= 2'd3;
                                end else begin
                                    tx <= frame_byte(seq_n, address);
                                end
                            end
                        end
                    end
                end
                C_BUSY: if (miso_q) begin
                    cs  <= 1'b1;
                    cst <= C_IDLE;
                end
                default: cst <= C_INIT;
            endcase
        end
    end
endmodule

module sd_card_block_writer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_spi,
    input  logic        reset_n,
    output logic        sd_sclk,
    output logic        sd_mosi,
    input  logic        sd_miso,
    output logic        sd_cs,
    input  logic [31:0] block_id,
    input  logic        start,
    output logic [8:0]  buf_addr,
    input  logic [7:0]  buf_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, WAIT_READY = 3'd1, ISSUE = 3'd2, WRITE = 3'd3,
        WAIT_DONE = 3'd4, DONE = 3'd5, ERROR = 3'd6
    } state_t;

    state_t      st;
    logic        wr;
    logic [7:0]  din;
    logic [31:0] addr_q;
    logic [9:0]  cnt;
    logic        ready;
    logic        rfnb;
    logic        rfnb_q;
    logic        rfnb_rise;
    logic [7:0]  dout;
    logic        byte_available;
    logic        unused_sink;

    sd_controller u_ctrl (
        .clk                 (clk_spi),
        .reset               (!reset_n),
        .cs                  (sd_cs),
        .mosi                (sd_mosi),
        .sclk                (sd_sclk),
        .miso                (sd_miso),
        .rd                  (1'b0),
        .dout                (dout),
        .byte_available      (byte_available),
        .wr                  (wr),
        .din                 (din),
        .ready               (ready),
        .ready_for_next_byte (rfnb),
        .address             (addr_q)
    );

    assign state       = st;
    assign busy        = (st != IDLE);
    assign rfnb_rise   = rfnb & ~rfnb_q;
    assign unused_sink = ^{dout, byte_available, (TIMEOUT_CYCLES != 0)};

`ifdef SDW_TIMEOUT_EN
    logic [31:0] tmo;
    logic        err_q;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk_spi or negedge reset_n) begin
        if (!reset_n) begin
            st       <= IDLE;
            done     <= 1'b0;
            wr       <= 1'b0;
            din      <= 8'h00;
            cnt      <= 10'd0;
            addr_q   <= 32'd0;
            buf_addr <= 9'd0;
            rfnb_q   <= 1'b0;
`ifdef SDW_TIMEOUT_EN
            tmo      <= 32'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            rfnb_q <= rfnb;
            wr     <= 1'b0;
            done   <= 1'b0;
            case (st)
                IDLE: if (start) begin
                    addr_q   <= block_id;
                    cnt      <= 10'd0;
                    buf_addr <= 9'd0;
                    st       <= WAIT_READY;
`ifdef SDW_TIMEOUT_EN
                    tmo      <= 32'd0;
                    err_q    <= 1'b0;
`endif
                end
                WAIT_READY: begin
                    buf_addr <= 9'd0;
                    if (ready) begin
                        wr <= 1'b1;
                        st <= ISSUE;
                    end
`ifdef SDW_TIMEOUT_EN
                    else begin
                        tmo <= tmo + 32'd1;
                        if (tmo + 32'd1 == TIMEOUT_CYCLES) begin
                            err_q <= 1'b1;
                            st    <= ERROR;
                        end
                    end
`endif
                end
                ISSUE: begin
                    din <= buf_data;
                    st  <= WRITE;
                end
                WRITE: begin
                    // The RAM output follows buf_addr one cycle late; tracking it keeps din current
                    din <= buf_data;
                    if (rfnb_rise) begin
                        cnt      <= cnt + 10'd1;
                        buf_addr <= (cnt == 10'd511) ? 9'd511 : cnt[8:0] + 9'd1;
                        if (cnt == 10'd511) begin
                            st <= WAIT_DONE;
`ifdef SDW_TIMEOUT_EN
                            tmo <= 32'd0;
`endif
                        end
                    end
                end
                WAIT_DONE: begin
                    if (ready) begin
                        done <= 1'b1;
                        st   <= DONE;
                    end
`ifdef SDW_TIMEOUT_EN
                    else begin
                        tmo <= tmo + 32'd1;
                        if (tmo + 32'd1 == TIMEOUT_CYCLES) begin
                            err_q <= 1'b1;
                            st    <= ERROR;
                        end
                    end
`endif
                end
                DONE:    st <= IDLE;
                ERROR:   st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_card_block_writer.sv
// Directed bench for sd_card_block_writer: decodes the SPI stream and checks handshakes and status.
module tb_sd_card_block_writer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        sd_sclk, sd_mosi, sd_miso, sd_cs;
    logic [31:0] block_id;
    logic        start;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;
    logic        busy, done, error;
    logic [2:0]  state;

    logic [7:0]  mem [512];
    logic [7:0]  rx_sh = 8'h00;
    int          rx_bits = 0;
    logic [7:0]  rx_q [$];

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_bad = 0;
    int max_cnt  = 0;

    always #5 clk = ~clk;

    sd_card_block_writer #(.TIMEOUT_CYCLES(1000)) dut (
        .clk_spi  (clk),
        .reset_n  (reset_n),
        .sd_sclk  (sd_sclk),
        .sd_mosi  (sd_mosi),
        .sd_miso  (sd_miso),
        .sd_cs    (sd_cs),
        .block_id (block_id),
        .start    (start),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .state    (state)
    );

    always @(posedge clk) buf_data <= mem[buf_addr];

    // SPI card side: sample MOSI on rising SCLK while selected
    always @(posedge sd_sclk or posedge sd_cs) begin
        if (sd_cs) rx_bits = 0;
        else begin
            rx_sh = {rx_sh[6:0], sd_mosi};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_q.push_back(rx_sh);
                rx_bits = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (dut.wr === 1'b1) wr_cnt++;
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (busy !== (state != 3'd0)) busy_bad++;
        if (int'(dut.cnt) > max_cnt) max_cnt = int'(dut.cnt);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] id);
        @(negedge clk);
        start    = 1'b1;
        block_id = id;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_cnt(input string tag, input int val, input int limit);
        int n = 0;
        while (int'(dut.cnt) != val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cnt_reached"}, {22'd0, dut.cnt}, val);
    endtask

    task automatic check_block(input string tag, input int b, input logic [31:0] id);
        int errs = 0;
        check({tag, "_nbytes"}, rx_q.size() - b, 32'd530);
        if (rx_q.size() >= b + 530) begin
            for (int k = 0; k < 512; k++)
                if (rx_q[b + 15 + k] !== (k[7:0] ^ 8'hA5)) errs++;
            check({tag, "_cmd"}, {24'd0, rx_q[b]}, 32'h58);
            check({tag, "_addr"}, {rx_q[b+1], rx_q[b+2], rx_q[b+3], rx_q[b+4]}, id);
            check({tag, "_token"}, {24'd0, rx_q[b+14]}, 32'hFE);
        end else begin
            errs = 512;
        end
        check({tag, "_data_errs"}, errs, 32'd0);
    endtask

    initial begin
        int b;
        int w0;
        int d0;
        reset_n  = 1'b0;
        start    = 1'b0;
        block_id = 32'd0;
        sd_miso  = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = i[7:0] ^ 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        check("rst_buf_addr", {23'd0, buf_addr}, 32'd0);
        check("rst_wr_din", {23'd0, dut.wr, dut.din}, 32'd0);
        check("rst_cnt", {22'd0, dut.cnt}, 32'd0);
        check("rst_cs", {31'd0, sd_cs}, 32'd1);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);

        // Basic block write to block 0x10
        b = rx_q.size(); w0 = wr_cnt; d0 = done_cnt;
        pulse_start(32'h0000_0010);
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done("t1", 12000);
        check("t1_state_done", {29'd0, state}, 32'd5);
        @(negedge clk);
        check("t1_state_idle", {29'd0, state}, 32'd0);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        check("t1_done_low", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("t1_done_pulses", done_cnt - d0, 32'd1);
        check("t1_wr_pulses", wr_cnt - w0, 32'd1);
        check("t1_cnt_final", {22'd0, dut.cnt}, 32'd512);
        check("t1_buf_addr_hold", {23'd0, buf_addr}, 32'd511);
        check_block("t1", b, 32'h0000_0010);

        // Card busy holds ready low: no wr until it releases
        sd_miso = 1'b0;
        b = rx_q.size(); w0 = wr_cnt;
        pulse_start(32'h0000_0020);
        repeat (5000) @(negedge clk);
        check("t2_wr_held", wr_cnt - w0, 32'd0);
        check("t2_state_wait", {29'd0, state}, 32'd1);
        sd_miso = 1'b1;
        wait_done("t2", 12000);
        check("t2_wr_one_cycle", wr_cnt - w0, 32'd1);
        repeat (3) @(negedge clk);
        check_block("t2", b, 32'h0000_0020);

        // Start while busy is ignored
        b = rx_q.size(); d0 = done_cnt;
        pulse_start(32'h0000_0010);
        wait_cnt("t3", 100, 5000);
        pulse_start(32'h0000_0099);
        check("t3_state_write", {29'd0, state}, 32'd3);
        wait_done("t3", 12000);
        repeat (3) @(negedge clk);
        check("t3_done_pulses", done_cnt - d0, 32'd1);
        check_block("t3", b, 32'h0000_0010);

        // Reset mid-transfer, then a clean block
        d0 = done_cnt;
        pulse_start(32'h0000_0010);
        wait_cnt("t4", 300, 8000);
        reset_n = 1'b0;
        @(negedge clk);
        check("t4_rst_state", {29'd0, state}, 32'd0);
        check("t4_rst_flags", {29'd0, busy, done, error}, 32'd0);
        check("t4_rst_buf_addr", {23'd0, buf_addr}, 32'd0);
        check("t4_rst_cs", {31'd0, sd_cs}, 32'd1);
        reset_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("t4_no_done", done_cnt - d0, 32'd0);
        b = rx_q.size();
        pulse_start(32'h0000_0030);
        wait_done("t4", 12000);
        repeat (3) @(negedge clk);
        check_block("t4", b, 32'h0000_0030);
        check("t4_cnt_final", {22'd0, dut.cnt}, 32'd512);

`ifdef SDW_TIMEOUT_EN
        begin
            int n = 0;
            int in4 = 0;
            pulse_start(32'h0000_0040);
            while (state != 3'd4 && n < 12000) begin
                @(negedge clk);
                n++;
            end
            check("t5_wait_done_entered", {29'd0, state}, 32'd4);
            sd_miso = 1'b0;
            while (state == 3'd4 && in4 < 1100) begin
                in4++;
                @(negedge clk);
            end
            check("t5_cycles_in_wait_done", in4, 32'd1000);
            check("t5_state_error", {29'd0, state}, 32'd6);
            check("t5_error_set", {31'd0, error}, 32'd1);
            @(negedge clk);
            check("t5_state_idle", {29'd0, state}, 32'd0);
            repeat (10) @(negedge clk);
            check("t5_error_sticky", {31'd0, error}, 32'd1);
            sd_miso = 1'b1;
            pulse_start(32'h0000_0041);
            check("t5_error_cleared", {31'd0, error}, 32'd0);
            wait_done("t5", 12000);
            repeat (3) @(negedge clk);
        end
`else
        check("no_error_ever", err_cnt, 32'd0);
`endif

        check("busy_matches_state", busy_bad, 32'd0);
        check("cnt_never_over_512", max_cnt, 32'd512);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
